// File: rtl/mem_access_unit.sv
// RV32I MEM-stage load/store unit: formats store lanes, drives a simple req/resp data memory
// handshake through an IDLE/REQ/DONE FSM and registers the formatted load result.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        mem_misaligned
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_t;

    state_t state;

    logic        is_mem;
    logic        size_half;
    logic        size_word;
    logic        misaligned_cond;
    logic        access;
    logic        is_store;
    logic        in_req;
    logic [31:0] rdata_shifted;
    logic [31:0] load_fmt;

    assign is_mem    = valid_in & (mem_read | mem_write);
    // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings behave as word)
    assign size_half = (funct3[1:0] == 2'b01);
    assign size_word = funct3[1];

    assign misaligned_cond = (size_half & addr[0]) | (size_word & (addr[1:0] != 2'b00));
    assign mem_misaligned  = is_mem & misaligned_cond;
    assign access          = is_mem & ~misaligned_cond;

    // A read+write control word is treated as a load
    assign is_store = mem_write & ~mem_read;
    assign in_req   = (state == StReq);

    assign mem_stall  = ((state == StIdle) & access) | in_req;
    assign dmem_read  = in_req & mem_read;
    assign dmem_write = in_req & is_store;
    assign dmem_addr  = {addr[31:2], 2'b00};

    always_comb begin
        dmem_wdata       = store_data;
        dmem_byte_enable = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                dmem_wdata       = {4{store_data[7:0]}};
                dmem_byte_enable = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                dmem_wdata       = {2{store_data[15:0]}};
                dmem_byte_enable = 4'b0011 << addr[1:0];
            end
            default: begin
                dmem_wdata       = store_data;
                dmem_byte_enable = 4'b1111;
            end
        endcase
        if (!(access & is_store)) begin
            dmem_byte_enable = 4'b0000;
        end
    end

    // Move the addressed lane down to bit 0, then extend by width and signedness
    assign rdata_shifted = dmem_rdata >> {addr[1:0], 3'b000};

    always_comb begin
        load_fmt = dmem_rdata;
        case (funct3)
            3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_fmt = {24'h000000, rdata_shifted[7:0]};
            3'b101:  load_fmt = {16'h0000, rdata_shifted[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            load_data <= 32'h0000_0000;
        end else begin
            case (state)
                StIdle: begin
                    if (access) begin
                        state <= StReq;
                    end
                end
                StReq: begin
                    if (dmem_resp) begin
                        state <= StDone;
                        if (mem_read) begin
                            load_data <= load_fmt;
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: expected request fields and load results are queued
// when each access is driven and compared when the DUT issues the request or completes.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        mem_misaligned;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int first_stall_cyc = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          chk_wd;
    } req_t;

    req_t        req_q[$];
    logic [31:0] load_q[$];

    mem_access_unit dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_stall        (mem_stall),
        .load_data        (load_data),
        .mem_misaligned   (mem_misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the DONE edge (or after the timeout).
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int waits,
                              input logic [31:0] exp_ld, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int exp_stall);
        req_t        r;
        logic [31:0] ld_before;
        int          stalls = 0;
        int          reqs = 0;
        int          waited = 0;
        bit          done = 0;
        bit          first = 1;
        r.rd     = rd;
        r.wr     = wr & ~rd;
        r.addr   = {a[31:2], 2'b00};
        r.be     = exp_be;
        r.wd     = exp_wd;
        r.chk_wd = wr & ~rd;
        req_q.push_back(r);
        if (rd) load_q.push_back(exp_ld);
        ld_before  = load_data;
        valid_in   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (dmem_read || dmem_write) begin
                if (reqs == 0) begin
                    r = req_q.pop_front();
                    checks++;
                    if (dmem_read !== r.rd || dmem_write !== r.wr) begin
                        failures++;
                        $display("FAIL %s req_kind: got rd=%b wr=%b, required rd=%b wr=%b",
                                 name, dmem_read, dmem_write, r.rd, r.wr);
                    end
                    checks++;
                    if (dmem_addr !== r.addr || dmem_byte_enable !== r.be) begin
                        failures++;
                        $display("FAIL %s req_addr_be: got addr=%h be=%b, required addr=%h be=%b",
                                 name, dmem_addr, dmem_byte_enable, r.addr, r.be);
                    end
                    if (r.chk_wd) begin
                        checks++;
                        if (dmem_wdata !== r.wd) begin
                            failures++;
                            $display("FAIL %s wdata: got %h, required %h", name, dmem_wdata, r.wd);
                        end
                    end
                end
                reqs++;
                if (waited == waits) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata;
                end
                waited++;
            end
            #1;
            if (mem_stall) begin
                if (first) first_stall_cyc = cyc;
                first = 0;
                stalls++;
            end else begin
                done = 1;
                last_done_cyc = cyc;
                checks++;
                if (rd) begin
                    exp_ld = load_q.pop_front();
                    if (load_data !== exp_ld) begin
                        failures++;
                        $display("FAIL %s load_data: got %h, required %h", name, load_data, exp_ld);
                    end
                end else if (load_data !== ld_before) begin
                    failures++;
                    $display("FAIL %s load_hold: got %h, required %h", name, load_data, ld_before);
                end
            end
            @(posedge clk);
            #1;
            dmem_resp  = 1'b0;
            dmem_rdata = 32'h5A5A_5A5A;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: stall still high after 40 cycles, required completion", name);
        end
        checks++;
        if (stalls !== exp_stall) begin
            failures++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_stall);
        end
        checks++;
        if (reqs !== waits + 1) begin
            failures++;
            $display("FAIL %s req_cycles: got %0d, required %0d", name, reqs, waits + 1);
        end
    endtask

    task automatic idle_inputs();
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (load_data !== 32'h0 || mem_stall !== 1'b0 || dmem_read !== 1'b0 ||
            dmem_write !== 1'b0 || mem_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset: got ld=%h stall=%b rd=%b wr=%b mis=%b, required all zero",
                     load_data, mem_stall, dmem_read, dmem_write, mem_misaligned);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        run_access("lb_1003", 1, 0, 3'b000, 32'h1003, 0, 32'h80AA_BBCC, 0, 32'hFFFF_FF80, 0, 0, 2);
        run_access("lhu_2002", 1, 0, 3'b101, 32'h2002, 0, 32'h9234_5678, 3, 32'h0000_9234, 0, 0, 5);
        run_access("lh_2002", 1, 0, 3'b001, 32'h2002, 0, 32'h9234_5678, 1, 32'hFFFF_9234, 0, 0, 3);
        run_access("lbu_1001", 1, 0, 3'b100, 32'h1001, 0, 32'h80AA_BBCC, 0, 32'h0000_00BB, 0, 0, 2);
        run_access("lb_1000", 1, 0, 3'b000, 32'h1000, 0, 32'h80AA_BBCC, 0, 32'hFFFF_FFCC, 0, 0, 2);
        run_access("lw_4000", 1, 0, 3'b010, 32'h4000, 0, 32'h1234_5678, 2, 32'h1234_5678, 0, 0, 4);
        run_access("rdwr_lw", 1, 1, 3'b010, 32'h0500, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0,
                   32'h0BAD_F00D, 4'b0000, 0, 2);
    endtask

    task automatic test_stores();
        run_access("sb_3001", 0, 1, 3'b000, 32'h3001, 32'h0000_00EE, 32'h0, 0, 0,
                   4'b0010, 32'hEEEE_EEEE, 2);
        run_access("sh_3002", 0, 1, 3'b001, 32'h3002, 32'h1234_ABCD, 32'h0, 1, 0,
                   4'b1100, 32'hABCD_ABCD, 3);
        run_access("sw_3008", 0, 1, 3'b010, 32'h3008, 32'hCAFE_BABE, 32'h0, 0, 0,
                   4'b1111, 32'hCAFE_BABE, 2);
    endtask

    task automatic test_misaligned();
        logic [31:0] ld_before;
        logic [2:0]  f3s[3] = '{3'b010, 3'b001, 3'b101};
        logic [31:0] adrs[3] = '{32'h4002, 32'h3001, 32'h2003};
        for (int i = 0; i < 3; i++) begin
            ld_before  = load_data;
            valid_in   = 1'b1;
            mem_read   = (i != 1);
            mem_write  = (i == 1);
            funct3     = f3s[i];
            addr       = adrs[i];
            store_data = 32'h1111_2222;
            #1;
            checks++;
            if (mem_misaligned !== 1'b1 || dmem_read !== 1'b0 || dmem_write !== 1'b0 ||
                mem_stall !== 1'b0 || dmem_byte_enable !== 4'b0000) begin
                failures++;
                $display("FAIL misaligned_%0d: got mis=%b rd=%b wr=%b stall=%b be=%b, required 1 0 0 0 0",
                         i, mem_misaligned, dmem_read, dmem_write, mem_stall, dmem_byte_enable);
            end
            @(posedge clk);
            #1;
            checks++;
            if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || load_data !== ld_before) begin
                failures++;
                $display("FAIL misaligned_next_%0d: got stall=%b rd=%b ld=%h, required 0 0 %h",
                         i, mem_stall, dmem_read, load_data, ld_before);
            end
        end
        // Flag is qualified by valid_in
        valid_in = 1'b0;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h4002;
        #1;
        checks++;
        if (mem_misaligned !== 1'b0 || mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_invalid: got mis=%b stall=%b, required 0 0",
                     mem_misaligned, mem_stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nonmem();
        logic [31:0] ld_before;
        ld_before = load_data;
        valid_in  = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0100;
        for (int i = 0; i < 3; i++) begin
            // A stray response outside REQ must not load anything
            dmem_resp  = 1'b1;
            dmem_rdata = 32'hFFFF_FFFF;
            #1;
            checks++;
            if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
                failures++;
                $display("FAIL nonmem_%0d: got stall=%b rd=%b wr=%b, required 0 0 0",
                         i, mem_stall, dmem_read, dmem_write);
            end
            @(posedge clk);
            #1;
        end
        dmem_resp = 1'b0;
        checks++;
        if (load_data !== ld_before) begin
            failures++;
            $display("FAIL nonmem_hold: got %h, required %h", load_data, ld_before);
        end
        valid_in = 1'b0;
    endtask

    task automatic test_rst_in_req();
        valid_in  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0040;
        @(posedge clk);
        #1;
        checks++;
        if (dmem_read !== 1'b1 || mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_req_enter: got rd=%b stall=%b, required 1 1", dmem_read, mem_stall);
        end
        rst      = 1'b1;
        valid_in = 1'b0;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h7777_7777;
        #1;
        checks++;
        if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || load_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_req_abandon: got stall=%b rd=%b ld=%h, required 0 0 00000000",
                     mem_stall, dmem_read, load_data);
        end
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        checks++;
        if (load_data !== 32'h0 || mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_req_late_resp: got ld=%h stall=%b, required 00000000 0",
                     load_data, mem_stall);
        end
    endtask

    task automatic test_back_to_back();
        int done_lw;
        run_access("b2b_lw", 1, 0, 3'b010, 32'h0010, 0, 32'h1111_2222, 0, 32'h1111_2222, 0, 0, 2);
        done_lw = last_done_cyc;
        run_access("b2b_sw", 0, 1, 3'b010, 32'h0014, 32'h3333_4444, 32'h0, 0, 0,
                   4'b1111, 32'h3333_4444, 2);
        checks++;
        if (first_stall_cyc !== done_lw + 1) begin
            failures++;
            $display("FAIL b2b_start: second access began cycle %0d, required %0d",
                     first_stall_cyc, done_lw + 1);
        end
        checks++;
        if (req_q.size() != 0 || load_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got req=%0d load=%0d left, required 0 0",
                     req_q.size(), load_q.size());
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_nonmem();
        test_rst_in_req();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
